// File: rtl/cla_addsub_pipe_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_addsub_pipe_pkg;

    localparam int GROUP_W = 4;   // bits per first-level lookahead group
    localparam int SUPER_W = 16;  // bits per super-group (4 groups)

    // Operand width must tile exactly into 16-bit super-groups.
    function automatic bit width_legal(input int w);
        return (w > 0) && ((w % SUPER_W) == 0);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-wide carry-lookahead cell: resolves carries into each of four positions
// and summarises the block as a single propagate/generate pair. Used for bit
// groups (level 1) and for groups of groups (level 2).
module cla_group4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] c,
    output logic       gp,
    output logic       gg
);

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage WIDTH-bit adder/subtractor. Stage 1 registers per-bit P/G and the
// carry-in; stage 2 resolves carries through two lookahead levels (super-groups
// chained serially) and registers sum and flags. Valid/ready on both sides.
module cla_addsub_pipe
    import cla_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSUP = WIDTH / SUPER_W;

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("cla_addsub_pipe: WIDTH must be a positive multiple of 16");
        end
    endgenerate

    // ---------------- handshake ----------------
    logic             s1_valid_r;
    logic             s1_load_s;
    logic             s2_load_s;

    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] g_r;
    logic             c0_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [WIDTH-1:0] bx_s;
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             ovf_s;

    // in_ready is held low during reset so nothing is accepted on release.
    assign s2_load_s = s1_valid_r & (~out_valid_r | out_ready);
    assign in_ready  = ~rst & (~s1_valid_r | s2_load_s);
    assign s1_load_s = in_valid & in_ready;

    // Subtract is A + ~B + 1: invert B here, carry-in 1 registered as c0.
    assign bx_s = b ^ {WIDTH{sub}};

    // Stage 1: capture propagate/generate and carry-in on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            p_r        <= '0;
            g_r        <= '0;
            c0_r       <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= 1'b1;
                p_r        <= a ^ bx_s;
                g_r        <= a & bx_s;
                c0_r       <= sub;
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end
        end
    end

    // ---------------- stage 2 carry network ----------------
    genvar s, k;
    generate
        for (s = 0; s < NSUP; s++) begin : g_sup
            logic [3:0] grp_p_s;
            logic [3:0] grp_g_s;
            logic [3:0] grp_c_s;
            logic       sup_p_s;
            logic       sup_g_s;
            logic       cin_s;
            logic       cout_s;

            // Super-groups ripple their carry into the next one.
            if (s == 0) begin : g_first
                assign cin_s = c0_r;
            end else begin : g_next
                assign cin_s = g_sup[s-1].cout_s;
            end

            // Level 2: four group p/g pairs -> carry into each group.
            cla_group4 u_lvl2 (
                .p   (grp_p_s),
                .g   (grp_g_s),
                .cin (cin_s),
                .c   (grp_c_s),
                .gp  (sup_p_s),
                .gg  (sup_g_s)
            );

            assign cout_s = sup_g_s | (sup_p_s & cin_s);

            for (k = 0; k < 4; k++) begin : g_grp
                // Level 1: bit carries within one 4-bit group.
                cla_group4 u_lvl1 (
                    .p   (p_r[s*SUPER_W + k*GROUP_W +: GROUP_W]),
                    .g   (g_r[s*SUPER_W + k*GROUP_W +: GROUP_W]),
                    .cin (grp_c_s[k]),
                    .c   (carry_s[s*SUPER_W + k*GROUP_W +: GROUP_W]),
                    .gp  (grp_p_s[k]),
                    .gg  (grp_g_s[k])
                );
            end
        end
    endgenerate

    assign carry_s[WIDTH] = g_sup[NSUP-1].cout_s;
    assign sum_s          = p_r ^ carry_s[WIDTH-1:0];
    assign cout_s         = carry_s[WIDTH];
    assign ovf_s          = carry_s[WIDTH-1] ^ carry_s[WIDTH];

    // Stage 2: register result when stage 1 advances; hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (s2_load_s) begin
                out_valid_r <= 1'b1;
                sum_r       <= sum_s;
                cout_r      <= cout_s;
                ovf_r       <= ovf_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe (WIDTH=16) with a result scoreboard.
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int accepts = 0;

    logic [17:0] sb_q[$];       // {ovf, cout, sum}
    bit          ovr_en = 1'b0; // push ovr_exp instead of the model result
    logic [17:0] ovr_exp;

    cla_addsub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic, signed overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic msub);
        logic [16:0] full;
        logic        v;
        if (msub) full = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
        else      full = {1'b0, ma} + {1'b0, mb};
        if (msub) v = (ma[15] != mb[15]) && (full[15] != ma[15]);
        else      v = (ma[15] == mb[15]) && (full[15] != ma[15]);
        return {v, full[16], full[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, observe handshakes, advance to next negedge.
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic ordy);
        logic [17:0] e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            pops++;
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sum",  {16'd0, sum},  {16'd0, e[15:0]});
                check("cout", {31'd0, cout}, {31'd0, e[16]});
                check("ovf",  {31'd0, ovf},  {31'd0, e[17]});
            end
        end
        if (in_valid && in_ready) begin
            accepts++;
            sb_q.push_back(ovr_en ? ovr_exp : model(a, b, sub));
        end
        @(negedge clk);
    endtask

    // Single op with spec-given expected result and latency check.
    task automatic single_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                             input logic [15:0] es, input logic ec, input logic ev);
        int p0;
        p0      = pops;
        ovr_en  = 1'b1;
        ovr_exp = {ev, ec, es};
        step(1'b1, ia, ib, isub, 1'b1);
        ovr_en  = 1'b0;
        check("lat_not_early", {31'd0, out_valid}, 32'd0);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        check("lat_at_2", pops - p0, 32'd0);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        check("lat_popped", pops - p0, 32'd1);
    endtask

    initial begin
        logic [15:0] held_sum;
        logic        held_c;
        logic        held_v;
        int          p0;
        int          a0;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_flags", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Directed arithmetic corners
        single_op(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
        single_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        single_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        single_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        single_op(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Stream 8 back-to-back, results on consecutive cycles
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1'b1, 16'(i * 16'h1357 + 16'h0F0F), 16'(i * 16'h2468), 1'(i % 2), 1'b1);
            else       step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
            if (i < 8) check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i >= 1) check("stream_pops", pops - p0, 32'(i - 1));
        end

        // Backpressure: out_ready low 5 cycles with continuous in_valid
        a0 = accepts;
        p0 = pops;
        held_sum = '0; held_c = 1'b0; held_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'hA5A5 + 16'(i), 16'h1234 + 16'(i * 3), 1'(i % 2), 1'b0);
            if (i == 2) begin
                held_sum = sum; held_c = cout; held_v = ovf;
            end
        end
        #1;
        check("bp_accepts", accepts - a0, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_sum_stable", {16'd0, sum}, {16'd0, held_sum});
        check("bp_flags_stable", {30'd0, cout, ovf}, {30'd0, held_c, held_v});
        check("bp_no_pop", pops - p0, 32'd0);
        for (int i = 0; i < 6 && sb_q.size() > 0; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        check("bp_drained", 32'(sb_q.size()), 32'd0);
        check("bp_total_pops", pops - p0, 32'd2);

        // Random traffic with random backpressure
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 8 && sb_q.size() > 0; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        check("rand_drained", 32'(sb_q.size()), 32'd0);

        // Reset with two ops in flight
        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_flight_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flight_sum", {16'd0, sum}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        p0 = pops;
        for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        check("rst_no_stale", pops - p0, 32'd0);
        single_op(16'h1234, 16'h0FFF, 1'b1, 16'h0235, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
